// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for the HI/LO unit: DIV/DIVU with
// divide-by-zero shortcut, cancel on pipeline flush, and a 32-cycle iteration.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              cancel_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_lo_o,
    output logic [DATA_W-1:0] result_hi_o
);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, ON, END} state_t;

    state_t            state, state_nx;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] quo, rem, dsr, dvd_raw;
    logic              neg_q, neg_r, div_by_zero;

    logic              accept;
    logic [DATA_W-1:0] dvd_mag, dsr_mag;
    logic [DATA_W:0]   shifted, trial;

    assign accept  = (state == IDLE) && start_i && !cancel_i;
    assign dvd_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    assign dsr_mag = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

    // Bring down the next dividend bit and try subtracting the divisor.
    assign shifted = {rem, quo[DATA_W-1]};
    assign trial   = shifted - {1'b0, dsr};

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start_i) state_nx = (divisor_i == '0) ? DIV_ZERO : ON;
            DIV_ZERO: state_nx = END;
            ON:       if (cnt == 6'(DATA_W - 1)) state_nx = END;
            END:      if (!start_i) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (cancel_i) state_nx = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dsr         <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            quo         <= dvd_mag;
            rem         <= '0;
            dsr         <= dsr_mag;
            dvd_raw     <= dividend_i;
            neg_q       <= signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            neg_r       <= signed_i && dividend_i[DATA_W-1];
            div_by_zero <= (divisor_i == '0);
        end else if (state == ON) begin
            cnt <= cnt + 6'd1;
            if (!trial[DATA_W]) begin
                rem <= trial[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= shifted[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        busy_o      = (state == DIV_ZERO) || (state == ON);
        done_o      = 1'b0;
        result_lo_o = '0;
        result_hi_o = '0;
        if (state == END) begin
            done_o = 1'b1;
            if (div_by_zero) begin
                result_lo_o = '1;
                result_hi_o = dvd_raw;
            end else begin
                result_lo_o = neg_q ? -quo : quo;
                result_hi_o = neg_r ? -rem : rem;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        cancel_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_lo_o;
    logic [31:0] result_hi_o;

    int checks   = 0;
    int failures = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .cancel_i    (cancel_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_lo_o (result_lo_o),
        .result_hi_o (result_hi_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic (truncating division).
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one division from IDLE, scramble operands after accept, wait for
    // done, check latency/results, optionally hold start, then release.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit drop_mid, input string tag);
        logic [63:0] exp;
        int exp_busy, nb, n;
        exp      = model(sgn, a, b);
        exp_busy = (b == 0) ? 1 : 32;
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        step();
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = ~sgn;
        nb = 0;
        n  = 0;
        while (!done_o && n < 40) begin
            if (busy_o) nb++;
            if (drop_mid && n == 5) start_i = 1'b0;
            step();
            n++;
        end
        check({tag, " busy_cycles"}, 64'(nb), 64'(exp_busy));
        check({tag, " done"}, {62'd0, busy_o, done_o}, 64'd1);
        check({tag, " result"}, {result_hi_o, result_lo_o}, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " hold"}, {result_hi_o, result_lo_o}, exp);
            check({tag, " hold_done"}, {62'd0, busy_o, done_o}, 64'd1);
        end
        start_i = 1'b0;
        step();
        check({tag, " idle_flags"}, {62'd0, busy_o, done_o}, 64'd0);
        check({tag, " idle_result"}, {result_hi_o, result_lo_o}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        cancel_i   = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        step();
        step();
        check("reset_flags", {62'd0, busy_o, done_o}, 64'd0);
        check("reset_result", {result_hi_o, result_lo_o}, 64'd0);
        rst = 1'b0;
        step();
        check("idle_after_reset", {62'd0, busy_o, done_o}, 64'd0);

        run_div(1'b0, 32'd100, 32'd7, 3, 1'b0, "u100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "s_m7_2");
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "u_m7_2");
        run_div(1'b0, 32'd5, 32'd0, 1, 1'b0, "u5_0");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 0, 1'b0, "s_m7_0");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "s_ovf");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, "s_7_m2");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "u_max_1");
        run_div(1'b0, 32'd3, 32'd10, 0, 1'b0, "u_small");
        run_div(1'b0, 32'd12345, 32'd17, 0, 1'b1, "start_drop");

        // start together with cancel in IDLE is ignored
        start_i  = 1'b1;
        cancel_i = 1'b1;
        divisor_i = 32'd3;
        step();
        check("start_cancel_idle", {62'd0, busy_o, done_o}, 64'd0);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        step();

        // cancel mid-division
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        step();
        repeat (10) step();
        check("busy_before_cancel", {63'd0, busy_o}, 64'd1);
        cancel_i = 1'b1;
        step();
        cancel_i = 1'b0;
        start_i  = 1'b0;
        check("cancel_flags", {62'd0, busy_o, done_o}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            step();
            check("cancel_no_done", {62'd0, busy_o, done_o}, 64'd0);
        end
        run_div(1'b0, 32'd9, 32'd3, 0, 1'b0, "after_cancel");

        // reset mid-division, then back-to-back start
        start_i    = 1'b1;
        signed_i   = 1'b1;
        dividend_i = 32'hDEAD_BEEF;
        divisor_i  = 32'd77;
        step();
        repeat (20) step();
        rst     = 1'b1;
        start_i = 1'b0;
        step();
        check("rst_mid_flags", {62'd0, busy_o, done_o}, 64'd0);
        check("rst_mid_result", {result_hi_o, result_lo_o}, 64'd0);
        rst = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, 0, 1'b0, "after_rst");

        for (int k = 0; k < 24; k++) begin
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(0, 9);
            b = (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 15)) : $urandom;
            a = (sel == 9) ? 32'h8000_0000 : $urandom;
            run_div(1'($urandom_range(0, 1)), a, b, 0, 1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  divide request from EX stage; held high until done_o is seen.
REQ-005 cancel_i  input  1  abort (pipeline flush/exception); highest priority after rst.
REQ-006 signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at accept.
REQ-007 dividend_i  input  DATA_W  rs operand; sampled at accept.
REQ-008 divisor_i  input  DATA_W  rt operand; sampled at accept.
REQ-009 busy_o  output  1  stall request to the pipeline while a division is in progress.
REQ-010 done_o  output  1  result valid; feeds the HI/LO write-enable path.
REQ-011 result_lo_o  output  DATA_W  quotient, destined for LO.
REQ-012 result_hi_o  output  DATA_W  remainder, destined for HI.

Function
REQ-013 FSM states SHALL be IDLE, DIV_ZERO, ON, END.
REQ-014 Accept: in IDLE with start_i=1 and cancel_i=0, SHALL latch operands and signed_i, then go to DIV_ZERO if divisor_i==0, else to ON.
REQ-015 ON SHALL perform restoring radix-2 division, one quotient bit per cycle, 32 iterations on the operand magnitudes, counted by a 6-bit counter cleared at accept.
REQ-016 Latency: with accept at edge E0, iterations occur at edges E1..E32; E32 SHALL enter END, so done_o is high in the cycle after E32.
REQ-017 DIV_ZERO SHALL go to END at the next edge; results SHALL be lo=all-ones and hi=latched dividend (raw, unsigned or signed alike).
REQ-018 Signed mode: magnitudes SHALL be taken from the operands; the quotient SHALL be negated when operand signs differ; the remainder SHALL take the dividend's sign.
REQ-019 Overflow case -2^31 / -1 (signed) SHALL yield lo=0x80000000, hi=0 (32-bit wrap, no trap).
REQ-020 In END, done_o=1 and results SHALL be stable; the FSM SHALL stay in END while start_i=1 and return to IDLE at the first edge with start_i=0.
REQ-021 busy_o SHALL be 1 exactly in DIV_ZERO and ON; it SHALL be 0 in IDLE and END.
REQ-022 done_o, result_lo_o, and result_hi_o SHALL be 0 in every state other than END.
REQ-023 cancel_i=1 in any state SHALL force IDLE at the next edge; done_o SHALL never assert for a cancelled operation; a start_i coinciding with cancel_i in IDLE SHALL be ignored.
REQ-024 start_i dropping during DIV_ZERO or ON (without cancel) SHALL NOT abort the division.
REQ-025 Operand changes after accept SHALL have no effect on the result.

Reset
REQ-026 rst=1 SHALL force IDLE, clear the counter and datapath registers, and drive busy_o=0, done_o=0, result_lo_o=0, result_hi_o=0 from the next edge, including mid-division.
REQ-027 After rst deasserts, the first start_i SHALL be accepted normally.

Verification
REQ-028 Unsigned 100/7 -> busy_o=1 for 32 cycles, then done_o=1 with lo=14, hi=2; hold start_i 3 more cycles -> outputs stable; drop start_i -> IDLE and outputs 0.
REQ-029 Signed -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; the same operands unsigned -> lo=0x7FFFFFFC, hi=1.
REQ-030 5/0 -> busy_o for 1 cycle, done_o in the cycle after the second edge, with lo=0xFFFFFFFF, hi=5.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0 after 32 cycles.
REQ-032 cancel_i pulsed at iteration 10 -> IDLE next edge, done_o stays 0; a new 9/3 then gives lo=3, hi=0 with full 32-cycle latency.
REQ-033 rst asserted at iteration 20 -> all outputs 0 next edge, FSM in IDLE; a back-to-back start after reset is accepted.
